ksa_rr_scheduler: RTL and testbench

- Shares one registered Kogge-Stone adder (1-cycle latency, DW-bit operands, sum + carry-out) among NREQ requesters.
- Uses round-robin arbitration with valid/ready handshakes.
- Supports multi-word (wide) additions: a requester holds the grant for a burst of words, and the scheduler chains each word's carry-out into the next word's carry-in.
- Results return on one tagged response channel, with no backpressure.

---
 rtl/ksa_rr_scheduler_if.sv | 36 +++
 rtl/ksa_rr_scheduler.sv | 126 ++++++++++++
 tb/tb_ksa_rr_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ksa_rr_scheduler_if.sv
// Request, shared-adder and tagged-response signals of the round-robin adder scheduler.
interface ksa_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 15,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_last;
  logic [DW-1:0]      add_a;
  logic [DW-1:0]      add_b;
  logic               add_cin;
  logic [DW-1:0]      add_sum;
  logic               add_cout;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_sum;
  logic               rsp_cout;
  logic               rsp_last;
  logic               busy;

  modport master (
    input  req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout,
    output req_ready, add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, busy
  );

  modport slave (
    output req_valid, req_a, req_b, req_cin, req_last, add_sum, add_cout,
    input  req_ready, add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_last, busy
  );
endinterface

// File: rtl/ksa_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder among NREQ requesters,
// with multi-word bursts whose carry is chained from word to word.
module ksa_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int DW   = 15,
  parameter int IDW  = 2
) (
  input logic                 CLK,
  input logic                 RESET,
  ksa_rr_scheduler_if.master  bus
);
  typedef enum logic [0:0] {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t         state_r, state_nxt_s;
  logic [IDW-1:0] ptr_r, owner_r;
  logic [IDW-1:0] arb_hi_s, arb_lo_s, sel_s, sel_inc_s;
  logic           found_hi_s, found_lo_s, grant_en_s;
  logic [NREQ-1:0] ready_s;
  logic           issue_s, last_s, cin_req_s, cin_s;
  logic [DW-1:0]  a_s, b_s;
  logic           prev_issue_r, prev_nonlast_r, carry_q_r;
  logic           rsp_valid_r, rsp_last_r;
  logic [IDW-1:0] rsp_id_r;

  // Round-robin search: lowest valid at/after ptr, else lowest valid overall
  always_comb begin
    found_hi_s = 1'b0;
    found_lo_s = 1'b0;
    arb_hi_s   = '0;
    arb_lo_s   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i] && (IDW'(i) >= ptr_r)) begin
        found_hi_s = 1'b1;
        arb_hi_s   = IDW'(i);
      end else if (bus.req_valid[i]) begin
        found_lo_s = 1'b1;
        arb_lo_s   = IDW'(i);
      end else begin
        found_lo_s = found_lo_s;
      end
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic: a non-last word opens a burst, a last word closes it
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: if (issue_s && !last_s) state_nxt_s = LOCK; else state_nxt_s = IDLE;
      LOCK: if (issue_s && last_s)  state_nxt_s = IDLE; else state_nxt_s = LOCK;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output logic: grant, issue and adder operand/carry selection
  always_comb begin
    sel_s      = (state_r == LOCK) ? owner_r : (found_hi_s ? arb_hi_s : arb_lo_s);
    grant_en_s = (state_r == LOCK) | found_hi_s | found_lo_s;
    ready_s    = '0;
    issue_s    = 1'b0;
    last_s     = 1'b0;
    cin_req_s  = 1'b0;
    a_s        = '0;
    b_s        = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel_s) begin
        ready_s[i] = grant_en_s;
        issue_s    = grant_en_s & bus.req_valid[i];
        last_s     = bus.req_last[i];
        cin_req_s  = bus.req_cin[i];
        a_s        = bus.req_a[i*DW +: DW];
        b_s        = bus.req_b[i*DW +: DW];
      end else begin
        ready_s[i] = 1'b0;
      end
    end
    // Back-to-back burst words take the live carry; after a gap the saved one
    if (!issue_s)               cin_s = 1'b0;
    else if (state_r == IDLE)   cin_s = cin_req_s;
    else if (prev_issue_r)      cin_s = bus.add_cout;
    else                        cin_s = carry_q_r;
    sel_inc_s = (sel_s == IDW'(NREQ - 1)) ? '0 : sel_s + IDW'(1);
  end

  // Pointer, owner, saved carry and response tag pipeline
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_r          <= '0;
      owner_r        <= '0;
      carry_q_r      <= 1'b0;
      prev_issue_r   <= 1'b0;
      prev_nonlast_r <= 1'b0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= '0;
      rsp_last_r     <= 1'b0;
    end else begin
      prev_issue_r   <= issue_s;
      prev_nonlast_r <= issue_s & ~last_s;
      rsp_valid_r    <= issue_s;
      rsp_id_r       <= sel_s;
      rsp_last_r     <= issue_s & last_s;
      if (issue_s && last_s) ptr_r <= sel_inc_s;
      else                   ptr_r <= ptr_r;
      if (issue_s && !last_s && (state_r == IDLE)) owner_r <= sel_s;
      else                                         owner_r <= owner_r;
      if (prev_nonlast_r) carry_q_r <= bus.add_cout;
      else                carry_q_r <= carry_q_r;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.add_a     = issue_s ? a_s : '0;
  assign bus.add_b     = issue_s ? b_s : '0;
  assign bus.add_cin   = cin_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_sum   = bus.add_sum;
  assign bus.rsp_cout  = bus.add_cout;
  assign bus.rsp_last  = rsp_last_r;
  assign bus.busy      = (state_r == LOCK) | rsp_valid_r;
endmodule

// File: tb/tb_ksa_rr_scheduler.sv
// Scoreboard bench for ksa_rr_scheduler: directed scenarios plus random traffic
// checked against an arithmetic round-robin/burst reference model.
module tb_ksa_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 15;
  localparam int IDW  = 2;

  typedef struct {
    int id;
    int sum;
    int cout;
    int last;
  } rsp_t;

  logic CLK = 1'b0;
  logic RESET;
  ksa_rr_scheduler_if #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) bus();

  ksa_rr_scheduler #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Shared registered adder
  always_ff @(posedge CLK)
    {bus.add_cout, bus.add_sum} <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{DW{1'b0}}, bus.add_cin};

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;
  rsp_t sb[$];

  logic [NREQ-1:0] v, cin, last;
  logic [DW-1:0]   a [NREQ];
  logic [DW-1:0]   b [NREQ];

  int m_ptr = 0;
  bit m_lock = 1'b0;
  int m_owner = 0;
  int m_carry = 0;
  bit m_prev_issue = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear();
    v = '0; cin = '0; last = '0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                          input logic c, input logic l);
    v[i] = 1'b1; a[i] = av; b[i] = bv; cin[i] = c; last[i] = l;
  endtask

  // One clock cycle: drive inputs, compare combinational outputs, advance the model
  task automatic step(input logic rst);
    int g;
    bit any;
    bit issue;
    int cin_eff;
    int s;
    logic [NREQ-1:0] exp_ready;
    @(posedge CLK);
    #1;
    RESET = rst;
    bus.req_valid = v;
    bus.req_cin   = cin;
    bus.req_last  = last;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*DW +: DW] = a[i];
      bus.req_b[i*DW +: DW] = b[i];
    end
    #1;
    any = 1'b0;
    g   = 0;
    if (m_lock) begin
      any = 1'b1;
      g   = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++)
        if (!any && v[(m_ptr + k) % NREQ]) begin
          any = 1'b1;
          g   = (m_ptr + k) % NREQ;
        end
    end
    exp_ready = any ? NREQ'(1 << g) : '0;
    issue     = any && v[g];
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("busy", 64'(bus.busy), 64'(m_lock | m_prev_issue));
    cin_eff = 0;
    s = 0;
    if (issue) begin
      cin_eff = m_lock ? m_carry : int'(cin[g]);
      s = int'(a[g]) + int'(b[g]) + cin_eff;
      check("add_a", 64'(bus.add_a), 64'(a[g]));
      check("add_b", 64'(bus.add_b), 64'(b[g]));
    end else begin
      check("add_a", 64'(bus.add_a), 64'd0);
      check("add_b", 64'(bus.add_b), 64'd0);
    end
    check("add_cin", 64'(bus.add_cin), 64'(cin_eff));
    if (rst) begin
      m_ptr = 0; m_lock = 1'b0; m_owner = 0; m_carry = 0; m_prev_issue = 1'b0;
    end else begin
      m_prev_issue = issue;
      if (issue) begin
        sb.push_back('{g, s % (1 << DW), s >> DW, int'(last[g])});
        if (last[g]) begin
          m_lock = 1'b0;
          m_ptr  = (g + 1) % NREQ;
        end else begin
          m_lock  = 1'b1;
          m_owner = g;
          m_carry = s >> DW;
        end
      end
    end
  endtask

  // Response monitor: every valid response must match the oldest expected one
  initial begin
    rsp_t e;
    wait (mon_en);
    forever begin
      @(negedge CLK);
      if (bus.rsp_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_spurious: got rsp_valid=%b id=%0d expected none at %0t",
                   bus.rsp_valid, bus.rsp_id, $time);
        end else begin
          e = sb.pop_front();
          check("rsp_id",   64'(bus.rsp_id),   64'(e.id));
          check("rsp_sum",  64'(bus.rsp_sum),  64'(e.sum));
          check("rsp_cout", 64'(bus.rsp_cout), 64'(e.cout));
          check("rsp_last", 64'(bus.rsp_last), 64'(e.last));
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    clear();
    bus.req_valid = '0; bus.req_cin = '0; bus.req_last = '0;
    bus.req_a = '0; bus.req_b = '0;
    repeat (2) @(posedge CLK);
    #1;
    mon_en = 1'b1;

    // Idle: nothing requested for 10 cycles
    clear();
    repeat (10) step(1'b0);

    // Single op from requester 0
    set_word(0, 15'h0003, 15'h0004, 1'b1, 1'b1);
    step(1'b0);
    clear();
    step(1'b0);

    // Rotation from reset with all requesters valid
    step(1'b1);
    repeat (5) begin
      for (int i = 0; i < NREQ; i++) set_word(i, DW'($urandom), DW'($urandom), 1'($urandom), 1'b1);
      step(1'b0);
    end
    clear();
    step(1'b0);

    // Chained carry on requester 2 (cin on the second word must be ignored)
    set_word(2, 15'h7FFF, 15'h0001, 1'b0, 1'b0);
    step(1'b0);
    clear();
    set_word(2, 15'h0000, 15'h0000, 1'b1, 1'b1);
    step(1'b0);
    clear();
    step(1'b0);

    // Lock with gap on requester 1 while 0 and 3 wait
    step(1'b1);
    set_word(1, 15'h7FFF, 15'h7FFF, 1'b0, 1'b0);
    step(1'b0);
    repeat (2) begin
      clear();
      set_word(0, 15'h0011, 15'h0022, 1'b0, 1'b1);
      set_word(3, 15'h0033, 15'h0044, 1'b1, 1'b1);
      step(1'b0);
    end
    set_word(1, 15'h0001, 15'h0002, 1'b0, 1'b0);
    step(1'b0);
    set_word(1, 15'h7FFF, 15'h0000, 1'b0, 1'b1);
    step(1'b0);
    clear();
    set_word(0, 15'h0011, 15'h0022, 1'b0, 1'b1);
    set_word(3, 15'h0033, 15'h0044, 1'b1, 1'b1);
    step(1'b0);
    clear();
    step(1'b0);

    // Reset in the cycle requester 0 issues word1 of a burst
    step(1'b1);
    set_word(0, 15'h7FFF, 15'h0005, 1'b1, 1'b0);
    step(1'b0);
    clear();
    set_word(0, 15'h1234, 15'h4321, 1'b0, 1'b0);
    step(1'b1);
    clear();
    set_word(3, 15'h0100, 15'h0200, 1'b1, 1'b1);
    step(1'b0);
    clear();
    repeat (2) step(1'b0);

    // Random traffic with bursts, gaps and occasional resets
    for (int n = 0; n < 3000; n++) begin
      clear();
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 9) < 6)
          set_word(i,
                   ($urandom_range(0, 3) == 0) ? 15'h7FFF : DW'($urandom),
                   ($urandom_range(0, 3) == 0) ? 15'h7FFF : DW'($urandom),
                   1'($urandom),
                   ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    clear();
    repeat (3) step(1'b0);
    @(posedge CLK);
    #1;
    check("drain", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
